// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: miss/refill sequencer between a CPU read port, cache_base and a memory read port; optional perf counters under CACHE_PERF_CNT_EN
module cache_refill_ctrl #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cpu_req,
    input  logic [31:0]      i_cpu_addr,
    output logic             o_cpu_valid,
    output logic             o_cpu_err,
    output logic [31:0]      o_cpu_rdata,
    input  logic             i_cache_hit,
    input  logic [31:0]      i_cache_rdata,
    output logic [31:0]      o_cache_addr,
    output logic             o_cache_wen,
    output logic [31:0]      o_cache_waddr,
    output logic [31:0]      o_cache_wdata,
    output logic             o_mem_valid,
    input  logic             i_mem_ready,
    output logic [31:0]      o_mem_addr,
    input  logic             i_mem_rvalid,
`ifdef CACHE_PERF_CNT_EN
    output logic [CNT_W-1:0] o_perf_hits,
    output logic [CNT_W-1:0] o_perf_misses,
`endif
    input  logic [31:0]      i_mem_rdata
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;
    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [TW-1:0] r_cnt;
    logic        w_hit_rsp;
    logic        w_miss;
    logic        w_timeout;
    assign w_hit_rsp = (r_state == IDLE) && i_cpu_req && i_cache_hit;
    assign w_miss    = (r_state == IDLE) && i_cpu_req && !i_cache_hit;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == TW'(TIMEOUT - 1));
    // Response, cache and memory port outputs decoded from the registered state
    always_comb begin
        o_cpu_valid   = w_hit_rsp || (r_state == FILL);
        o_cpu_err     = (r_state == WAIT) && !i_mem_rvalid && w_timeout;
        o_cpu_rdata   = w_hit_rsp ? i_cache_rdata : (r_state == FILL) ? r_data : 32'h0;
        o_cache_addr  = (r_state == FILL) ? r_addr : i_cpu_addr;
        o_cache_wen   = (r_state == FILL);
        o_cache_waddr = r_addr;
        o_cache_wdata = r_data;
        o_mem_valid   = (r_state == REQ);
        o_mem_addr    = {r_addr[31:2], 2'b00};
    end
    // Sequencer: one outstanding miss, request/wait/fill then back to idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_miss) begin
                    r_addr  <= i_cpu_addr;
                    r_state <= REQ;
                end
                REQ: if (i_mem_ready) begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: if (i_mem_rvalid) begin
                    r_data  <= i_mem_rdata;
                    r_state <= FILL;
                end else if (w_timeout) begin
                    r_state <= IDLE;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
`ifdef CACHE_PERF_CNT_EN
    // Hit/miss counters, wrapping at CNT_W bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_perf_hits   <= '0;
            o_perf_misses <= '0;
        end else begin
            if (w_hit_rsp) o_perf_hits <= o_perf_hits + 1'b1;
            if (w_miss) o_perf_misses <= o_perf_misses + 1'b1;
        end
    end
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = CNT_W[0];
`endif
endmodule
